id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with load-use hazard detection, placed directly downstream of the register file. It captures the two read operands, the register specifiers, the sign-extended immediate and the decoded control of the instruction in ID, and presents them registered to EX. A write-back bypass covers same-cycle register-file writes. The block generates the pipeline stall, inserts bubbles, honours branch flushes and EX back-pressure, and counts inserted bubbles.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register specifier width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- rd_data1, rd_data2  in  DATA_W  register-file read data for rs, rt
- id_rs, id_rt, id_rd  in  REG_W  register specifiers
- id_imm  in  16  raw immediate
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_mem_to_reg  in  1  decoded control
- id_alu_op  in  4  ALU operation
- wb_reg_write  in  1  write-back is writing this cycle
- wb_reg  in  REG_W  write-back destination
- wb_data  in  DATA_W  write-back data
- flush  in  1  branch/jump taken; kill the instruction entering EX
- ex_hold  in  1  EX is busy; freeze ID/EX
- stall  out  1  combinational; freeze PC and IF/ID
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg  out  1  registered control
- ex_alu_op  out  4  registered ALU op
- ex_op1, ex_op2  out  DATA_W  registered operands
- ex_imm  out  DATA_W  registered sign-extended immediate
- ex_rs, ex_rt  out  REG_W  registered sources (for forwarding)
- ex_wr_reg  out  REG_W  registered destination: id_reg_dst ? id_rd : id_rt
- bubble_cnt  out  CNT_W  number of bubbles inserted, saturating

## Operation
- Operand bypass: op1 = wb_data if wb_reg_write && wb_reg != 0 && wb_reg == id_rs, else rd_data1. op2 is computed the same way with id_rt and rd_data2. Register 0 is never bypassed.
- Immediate: ex_imm = {{(DATA_W-16){id_imm[15]}}, id_imm}.
- hazard = ex_valid && ex_mem_read && ex_wr_reg != 0 && id_valid && ((id_uses_rs && id_rs == ex_wr_reg) || (id_uses_rt && id_rt == ex_wr_reg)).
- stall = hazard | ex_hold.
- Per-posedge action, in strict priority order:
  - flush: load a bubble.
  - ex_hold: keep all ex_* unchanged.
  - hazard: load a bubble and increment bubble_cnt.
  - otherwise: load the ID contents, with ex_valid = id_valid.
- Bubble: ex_valid and all ex_* control bits = 0, ex_wr_reg = 0. Data/specifier fields are don't-care; the RTL drives them to 0.
- When id_valid = 0, control fields are loaded as 0, so an invalid slot never writes or accesses memory.
- bubble_cnt increments only when a bubble is inserted because of a hazard, with no flush and no hold. It saturates at all-ones and does not wrap.

## Timing
- Latency: one cycle from ID inputs to ex_* outputs.
- stall is combinational from the current ex_* state and ID inputs, and is valid in the same cycle.
- Load-use costs exactly one bubble. In the cycle after the bubble, the load has left EX, hazard drops, and the held ID instruction loads.
- Reset (rst = 0, asynchronous): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0. stall then reflects only ex_hold. Reset mid-operation discards the in-flight instruction. Release is synchronous to the next posedge.
- flush and hazard in the same cycle: flush wins and bubble_cnt is not incremented.
- ex_hold and flush in the same cycle: flush wins and the stage is cleared.
- ex_hold and hazard in the same cycle: hold wins. stall = 1, no bubble is inserted, and the counter is unchanged.
- wb bypass and hazard on the same register: the bypass applies to the captured value, and the hazard still stalls.

## Test plan
- Reset: hold rst = 0 and drive random ID inputs -> all ex_* = 0, bubble_cnt = 0, stall = 0. On release, the next posedge captures ID.
- Pass-through: rd_data1 = 0x11, rd_data2 = 0x22, id_imm = 0x8001, id_reg_dst = 1, id_rd = 7 -> next cycle ex_op1 = 0x11, ex_op2 = 0x22, ex_imm = 0xFFFF8001, ex_wr_reg = 7, ex_valid = 1.
- Load-use: lw with rt = 5 in EX, then add with rs = 5 and id_uses_rs = 1 in ID -> stall = 1 for one cycle, a bubble enters EX, bubble_cnt = 1. The add loads the following cycle.
- No false hazard: lw with rt = 0 in EX, ID reads r0 -> stall = 0. A lw to r5 with an ID instruction that has id_uses_rt = 0 and rt = 5 -> stall = 0.
- WB bypass: wb_reg_write = 1, wb_reg = 3, wb_data = 0xDEAD, id_rs = 3, rd_data1 = 0x0 -> ex_op1 = 0xDEAD. The same case with wb_reg = 0 -> ex_op1 = 0x0.
- Priority: flush with ex_hold -> bubble. ex_hold with hazard -> outputs frozen and bubble_cnt unchanged. Force bubble_cnt to 0xFFFF and then trigger a hazard -> bubble_cnt stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands, specifiers, immediate and control for EX,
// with write-back bypass, load-use stall, flush/hold handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [15:0]       id_imm,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_mem_to_reg,
  input  logic [3:0]        id_alu_op,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_wr_reg,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic              mem_to_reg;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  wr_reg;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic              rs_hit, rt_hit, hazard;
  logic              byp1, byp2;
  logic [DATA_W-1:0] op1_byp, op2_byp, imm_ext;

  always_comb begin
    rs_hit = id_uses_rs && (id_rs == ex_q.wr_reg);
    rt_hit = id_uses_rt && (id_rt == ex_q.wr_reg);
    hazard = ex_q.valid && ex_q.mem_read && (ex_q.wr_reg != '0) && id_valid &&
             (rs_hit || rt_hit);
  end

  assign stall = hazard | ex_hold;

  // Register 0 is hard-wired, so a write to it must never be bypassed.
  always_comb begin
    byp1    = wb_reg_write && (wb_reg != '0) && (wb_reg == id_rs);
    byp2    = wb_reg_write && (wb_reg != '0) && (wb_reg == id_rt);
    op1_byp = byp1 ? wb_data : rd_data1;
    op2_byp = byp2 ? wb_data : rd_data2;
    imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};
  end

  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (ex_hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      // An invalid slot carries no control so it can never write or touch memory.
      ex_d.valid      = id_valid;
      ex_d.reg_write  = id_valid & id_reg_write;
      ex_d.mem_read   = id_valid & id_mem_read;
      ex_d.mem_write  = id_valid & id_mem_write;
      ex_d.alu_src    = id_valid & id_alu_src;
      ex_d.mem_to_reg = id_valid & id_mem_to_reg;
      ex_d.alu_op     = id_valid ? id_alu_op : 4'h0;
      ex_d.op1        = op1_byp;
      ex_d.op2        = op2_byp;
      ex_d.imm        = imm_ext;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.wr_reg     = id_valid ? (id_reg_dst ? id_rd : id_rt) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_op1        = ex_q.op1;
  assign ex_op2        = ex_q.op2;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_wr_reg     = ex_q.wr_reg;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with constant expectations, then a randomized
// run against a behavioural model; a second instance with a 2-bit counter checks saturation.
module tb_id_ex_stage;

  logic        clk, rst;
  logic        id_valid;
  logic [31:0] rd_data1, rd_data2;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_mem_to_reg;
  logic [3:0]  id_alu_op;
  logic        wb_reg_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush, ex_hold;

  logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic        ex_mem_to_reg;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wr_reg;
  logic [15:0] bubble_cnt;

  logic        s_stall, s_valid, s_rw, s_mr, s_mw, s_as, s_mtr;
  logic [3:0]  s_alu_op;
  logic [31:0] s_op1, s_op2, s_imm;
  logic [4:0]  s_rs, s_rt, s_wr;
  logic [1:0]  s_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  id_ex_stage u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_reg(ex_wr_reg),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .ex_hold(ex_hold), .stall(s_stall), .ex_valid(s_valid), .ex_reg_write(s_rw),
    .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_alu_src(s_as),
    .ex_mem_to_reg(s_mtr), .ex_alu_op(s_alu_op), .ex_op1(s_op1), .ex_op2(s_op2),
    .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_wr_reg(s_wr),
    .bubble_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 0; rd_data1 = 0; rd_data2 = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_alu_src = 0; id_reg_dst = 0; id_mem_to_reg = 0; id_alu_op = 0;
    wb_reg_write = 0; wb_reg = 0; wb_data = 0; flush = 0; ex_hold = 0;
  endtask

  task automatic drive_load(input logic [4:0] rt, input logic [31:0] base);
    drive_idle();
    id_valid = 1; id_rs = 5'd1; id_rt = rt; id_uses_rs = 1; rd_data1 = base;
    id_reg_write = 1; id_mem_read = 1; id_alu_src = 1; id_mem_to_reg = 1; id_imm = 16'h0004;
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive_idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = 1; id_uses_rt = 1;
    id_reg_write = 1; id_reg_dst = 1; id_alu_op = 4'h2;
    rd_data1 = $urandom; rd_data2 = $urandom;
  endtask

  task automatic drive_random_id();
    id_valid = 1'($urandom); rd_data1 = $urandom; rd_data2 = $urandom;
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom); id_imm = 16'($urandom);
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_read = 1'($urandom); id_mem_write = 1'($urandom); id_alu_src = 1'($urandom);
    id_reg_dst = 1'($urandom); id_mem_to_reg = 1'($urandom); id_alu_op = 4'($urandom);
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    drive_idle();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      drive_random_id();
      wb_reg_write = 1'($urandom); wb_reg = 5'($urandom); wb_data = $urandom;
      tick();
      outs = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg,
              stall, |ex_op1, |bubble_cnt};
      checks++;
      if (outs !== 9'h0 || ex_alu_op !== 4'h0 || ex_op2 !== 32'h0 || ex_imm !== 32'h0 ||
          ex_wr_reg !== 5'h0 || ex_rs !== 5'h0 || ex_rt !== 5'h0) begin
        errors++;
        $display("FAIL reset_state: flags=%b alu_op=%h op2=%h imm=%h wr=%0d expected all 0",
                 outs, ex_alu_op, ex_op2, ex_imm, ex_wr_reg);
      end
    end
    drive_add(5'd2, 5'd3, 5'd4);
    rd_data1 = 32'hA5A5_0001;
    rst = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_wr_reg !== 5'd4 || ex_op1 !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL reset_release: valid=%b wr=%0d op1=%h expected 1/4/a5a50001",
               ex_valid, ex_wr_reg, ex_op1);
    end
  endtask

  task automatic test_pass_through();
    drive_idle();
    id_valid = 1; rd_data1 = 32'h11; rd_data2 = 32'h22; id_imm = 16'h8001;
    id_reg_dst = 1; id_rd = 5'd7; id_rs = 5'd8; id_rt = 5'd9; id_reg_write = 1;
    id_alu_op = 4'hA; id_alu_src = 1; id_mem_write = 1;
    tick();
    checks++;
    if (ex_op1 !== 32'h11 || ex_op2 !== 32'h22 || ex_imm !== 32'hFFFF_8001 ||
        ex_wr_reg !== 5'd7 || ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_rt !== 5'd9) begin
      errors++;
      $display("FAIL pass_through: op1=%h op2=%h imm=%h wr=%0d v=%b rs=%0d rt=%0d", ex_op1,
               ex_op2, ex_imm, ex_wr_reg, ex_valid, ex_rs, ex_rt);
    end
    checks++;
    if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg} !== 5'b10110 ||
        ex_alu_op !== 4'hA) begin
      errors++;
      $display("FAIL pass_ctrl: ctrl=%b alu_op=%h expected 10110/a",
               {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg}, ex_alu_op);
    end
    id_imm = 16'h7FFE; id_reg_dst = 0; id_rt = 5'd12; id_valid = 0;
    tick();
    checks++;
    if (ex_imm !== 32'h0000_7FFE || ex_valid !== 1'b0 || ex_reg_write !== 1'b0 ||
        ex_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL invalid_slot: imm=%h v=%b rw=%b mw=%b expected 00007ffe/0/0/0", ex_imm,
               ex_valid, ex_reg_write, ex_mem_write);
    end
  endtask

  task automatic test_load_use();
    drive_load(5'd5, 32'h100);
    tick();
    drive_add(5'd5, 5'd6, 5'd8);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b expected 1", stall);
    end
    tick();
    exp_cnt++;
    checks++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 ||
        ex_wr_reg !== 5'd0 || bubble_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL load_use_bubble: v=%b mr=%b rw=%b wr=%0d cnt=%0d expected 0/0/0/0/%0d",
               ex_valid, ex_mem_read, ex_reg_write, ex_wr_reg, bubble_cnt, exp_cnt);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: stall=%b expected 0", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_wr_reg !== 5'd8 || ex_rs !== 5'd5 || bubble_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL load_use_resume: v=%b wr=%0d rs=%0d cnt=%0d expected 1/8/5/%0d",
               ex_valid, ex_wr_reg, ex_rs, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_no_false_hazard();
    drive_load(5'd0, 32'h200);
    tick();
    drive_add(5'd0, 5'd0, 5'd9);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL no_hazard_r0: stall=%b expected 0", stall);
    end
    drive_load(5'd5, 32'h300);
    tick();
    drive_add(5'd2, 5'd5, 5'd9);
    id_uses_rt = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL no_hazard_unused_rt: stall=%b expected 0", stall);
    end
    drive_add(5'd5, 5'd5, 5'd9);
    id_valid = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL no_hazard_invalid_id: stall=%b expected 0", stall);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_wb_bypass();
    drive_add(5'd3, 5'd3, 5'd10);
    rd_data1 = 32'h0; rd_data2 = 32'h1234;
    wb_reg_write = 1; wb_reg = 5'd3; wb_data = 32'hDEAD;
    tick();
    checks++;
    if (ex_op1 !== 32'hDEAD || ex_op2 !== 32'hDEAD) begin
      errors++;
      $display("FAIL wb_bypass: op1=%h op2=%h expected dead/dead", ex_op1, ex_op2);
    end
    drive_add(5'd0, 5'd4, 5'd10);
    rd_data1 = 32'h55; rd_data2 = 32'h66;
    wb_reg_write = 1; wb_reg = 5'd0; wb_data = 32'hDEAD;
    tick();
    checks++;
    if (ex_op1 !== 32'h55 || ex_op2 !== 32'h66) begin
      errors++;
      $display("FAIL wb_bypass_r0: op1=%h op2=%h expected 55/66", ex_op1, ex_op2);
    end
    drive_load(5'd4, 32'h400);
    tick();
    drive_add(5'd4, 5'd1, 5'd11);
    rd_data1 = 32'h0;
    wb_reg_write = 1; wb_reg = 5'd4; wb_data = 32'hBEEF;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL bypass_hazard_stall: stall=%b expected 1", stall);
    end
    tick();
    exp_cnt++;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'hBEEF || bubble_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL bypass_hazard_load: v=%b op1=%h cnt=%0d expected 1/beef/%0d", ex_valid,
               ex_op1, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_priority();
    drive_add(5'd1, 5'd2, 5'd3);
    tick();
    drive_add(5'd4, 5'd5, 5'd6);
    ex_hold = 1; flush = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL hold_stall: stall=%b expected 1", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_wr_reg !== 5'd0) begin
      errors++;
      $display("FAIL flush_over_hold: v=%b rw=%b wr=%0d expected 0/0/0", ex_valid,
               ex_reg_write, ex_wr_reg);
    end
    drive_load(5'd6, 32'h600);
    tick();
    drive_add(5'd6, 5'd7, 5'd12);
    ex_hold = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL hold_hazard_stall: stall=%b expected 1", stall);
    end
    tick();
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_wr_reg !== 5'd6 ||
        ex_op1 !== 32'h600 || bubble_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL hold_over_hazard: v=%b mr=%b wr=%0d op1=%h cnt=%0d expected 1/1/6/600/%0d",
               ex_valid, ex_mem_read, ex_wr_reg, ex_op1, bubble_cnt, exp_cnt);
    end
    ex_hold = 0;
    tick();
    exp_cnt++;
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL hazard_after_hold: v=%b cnt=%0d expected 0/%0d", ex_valid, bubble_cnt,
               exp_cnt);
    end
    drive_load(5'd6, 32'h700);
    tick();
    drive_add(5'd6, 5'd7, 5'd12);
    flush = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_wr_reg !== 5'd0 || bubble_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL flush_over_hazard: v=%b wr=%0d cnt=%0d expected 0/0/%0d", ex_valid,
               ex_wr_reg, bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    for (int i = 0; i < 4; i++) begin
      drive_load(5'd9, 32'h900);
      tick();
      drive_add(5'd1, 5'd9, 5'd13);
      tick();
      exp_cnt++;
    end
    exp_sat = (exp_cnt > 16'd3) ? 2'd3 : exp_cnt[1:0];
    checks++;
    if (s_cnt !== exp_sat || bubble_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL counter_saturate: small=%0d main=%0d expected %0d/%0d", s_cnt, bubble_cnt,
               exp_sat, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic        m_valid, m_rw, m_mr, m_mw, m_as, m_mtr, hz;
    logic [3:0]  m_alu_op;
    logic [31:0] m_op1, m_op2, m_imm;
    logic [4:0]  m_rs, m_rt, m_wr;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;
    drive_add(5'd1, 5'd2, 5'd3);
    tick();
    rst = 0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 16'd0 || s_cnt !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: v=%b cnt=%0d small=%0d expected 0/0/0", ex_valid, bubble_cnt,
               s_cnt);
    end
    tick();
    rst = 1;
    {m_valid, m_rw, m_mr, m_mw, m_as, m_mtr} = '0;
    m_alu_op = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_wr = 0;
    m_cnt = 0; m_cnt2 = 0;
    for (int i = 0; i < 400; i++) begin
      drive_random_id();
      id_valid  = ($urandom_range(0, 9) != 0);
      id_rs     = 5'($urandom_range(0, 3));
      id_rt     = 5'($urandom_range(0, 3));
      id_rd     = 5'($urandom_range(0, 3));
      id_mem_read  = ($urandom_range(0, 4) < 2);
      wb_reg_write = 1'($urandom); wb_reg = 5'($urandom_range(0, 3)); wb_data = $urandom;
      ex_hold   = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      #1;
      hz = m_valid && m_mr && (m_wr != 0) && id_valid &&
           ((id_uses_rs && id_rs == m_wr) || (id_uses_rt && id_rt == m_wr));
      checks++;
      if (stall !== (hz || ex_hold)) begin
        errors++;
        $display("FAIL rand_stall[%0d]: stall=%b expected %b", i, stall, hz || ex_hold);
      end
      if (flush || (hz && !ex_hold)) begin
        {m_valid, m_rw, m_mr, m_mw, m_as, m_mtr} = '0;
        m_wr = 0;
        if (!flush) begin
          if (m_cnt != 16'hFFFF) m_cnt++;
          if (m_cnt2 != 2'd3) m_cnt2++;
        end
      end else if (!ex_hold) begin
        m_valid = id_valid;
        {m_rw, m_mr, m_mw, m_as, m_mtr} = id_valid ?
            {id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_mem_to_reg} : 5'b0;
        m_alu_op = id_alu_op;
        m_op1 = (wb_reg_write && wb_reg != 0 && wb_reg == id_rs) ? wb_data : rd_data1;
        m_op2 = (wb_reg_write && wb_reg != 0 && wb_reg == id_rt) ? wb_data : rd_data2;
        m_imm = 32'(signed'(id_imm));
        m_rs = id_rs; m_rt = id_rt;
        m_wr = id_reg_dst ? id_rd : id_rt;
      end
      tick();
      checks++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg} !==
          {m_valid, m_rw, m_mr, m_mw, m_as, m_mtr} || bubble_cnt !== m_cnt || s_cnt !== m_cnt2)
      begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: ctrl=%b cnt=%0d small=%0d expected %b/%0d/%0d", i,
                 {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg},
                 bubble_cnt, s_cnt, {m_valid, m_rw, m_mr, m_mw, m_as, m_mtr}, m_cnt, m_cnt2);
      end
      if (m_valid) begin
        checks++;
        if (ex_op1 !== m_op1 || ex_op2 !== m_op2 || ex_imm !== m_imm || ex_rs !== m_rs ||
            ex_rt !== m_rt || ex_wr_reg !== m_wr || ex_alu_op !== m_alu_op) begin
          errors++;
          $display("FAIL rand_data[%0d]: op1=%h op2=%h imm=%h rs=%0d rt=%0d wr=%0d alu=%h %s",
                   i, ex_op1, ex_op2, ex_imm, ex_rs, ex_rt, ex_wr_reg, ex_alu_op,
                   $sformatf("expected %h %h %h %0d %0d %0d %h", m_op1, m_op2, m_imm, m_rs,
                             m_rt, m_wr, m_alu_op));
        end
      end
    end
  endtask

  initial begin
    rst = 0;
    drive_idle();
    #2;
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_wb_bypass();
    test_priority();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
